// File: rtl/trap_ctrl_if.sv
// Bundle between write-back, the trap sequencer and the CSR file port.
// master drives the retiring-instruction side and CSR read data.
interface trap_ctrl_if;
    logic        wb_valid;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        illegal_inst;
    logic        ecall;
    logic        l_fault;
    logic        s_fault;
    logic        mret;
    logic        irq_ext;
    logic [31:0] mstatus;
    logic [31:0] csr_rdata;
    logic [11:0] csr_raddr;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        csr_w;
    logic [1:0]  csr_wsc_mode;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output wb_valid, trap_pc, trap_val,
        output illegal_inst, ecall, l_fault, s_fault,
        output mret, irq_ext, mstatus, csr_rdata,
        input  csr_raddr, csr_waddr, csr_wdata, csr_w,
        input  csr_wsc_mode, busy, redirect, redirect_pc
    );

    modport slave (
        input  wb_valid, trap_pc, trap_val,
        input  illegal_inst, ecall, l_fault, s_fault,
        input  mret, irq_ext, mstatus, csr_rdata,
        output csr_raddr, csr_waddr, csr_wdata, csr_w,
        output csr_wsc_mode, busy, redirect, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: saves/restores trap CSRs over the single
// CSR port, stalls the pipeline, then redirects fetch for one cycle.
module trap_ctrl (
    input logic         clk,
    input logic         rst,
    trap_ctrl_if.slave  bus
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE,
        W_MEPC,
        W_MCAUSE,
        W_MTVAL,
        W_MSTAT,
        R_MSTAT,
        JUMP
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic [31:0] tval_q;
    logic        ret_q;

    logic        irq_take;
    logic        trap_hit;
    logic        mret_hit;
    logic [31:0] cause_d;
    logic [31:0] tval_d;
    logic [31:0] vec_base;

    // Reset gates acceptance so every output stays quiet while rst is held.
    always_comb begin
        irq_take = bus.irq_ext & bus.mstatus[3];
        trap_hit = bus.wb_valid & ~rst &
                   (irq_take | bus.illegal_inst | bus.ecall |
                    bus.l_fault | bus.s_fault);
        mret_hit = bus.wb_valid & ~rst & bus.mret & ~trap_hit;
        cause_d  = 32'd0;
        tval_d   = 32'd0;
        if (irq_take) begin
            cause_d = 32'h8000_000B;
        end else if (bus.illegal_inst) begin
            cause_d = 32'd2;
            tval_d  = bus.trap_val;
        end else if (bus.ecall) begin
            cause_d = 32'd11;
        end else if (bus.l_fault) begin
            cause_d = 32'd5;
            tval_d  = bus.trap_val;
        end else if (bus.s_fault) begin
            cause_d = 32'd7;
            tval_d  = bus.trap_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pc_q    <= 32'd0;
            cause_q <= 32'd0;
            tval_q  <= 32'd0;
            ret_q   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && trap_hit) begin
                pc_q    <= bus.trap_pc;
                cause_q <= cause_d;
                tval_q  <= tval_d;
                ret_q   <= 1'b0;
            end else if (state == IDLE && mret_hit) begin
                ret_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx         = state;
        bus.csr_raddr    = A_MSTATUS;
        bus.csr_waddr    = 12'h000;
        bus.csr_wdata    = 32'd0;
        bus.csr_w        = 1'b0;
        bus.csr_wsc_mode = 2'b01;
        bus.busy         = (state != IDLE);
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'd0;
        vec_base         = {bus.csr_rdata[31:2], 2'b00};
        unique case (state)
            IDLE: begin
                bus.busy = trap_hit | mret_hit;
                if (trap_hit)
                    state_nx = W_MEPC;
                else if (mret_hit)
                    state_nx = R_MSTAT;
            end
            W_MEPC: begin
                bus.csr_w     = 1'b1;
                bus.csr_waddr = A_MEPC;
                bus.csr_wdata = pc_q;
                state_nx      = W_MCAUSE;
            end
            W_MCAUSE: begin
                bus.csr_w     = 1'b1;
                bus.csr_waddr = A_MCAUSE;
                bus.csr_wdata = cause_q;
                state_nx      = W_MTVAL;
            end
            W_MTVAL: begin
                bus.csr_w     = 1'b1;
                bus.csr_waddr = A_MTVAL;
                bus.csr_wdata = tval_q;
                state_nx      = W_MSTAT;
            end
            W_MSTAT: begin
                bus.csr_w     = 1'b1;
                bus.csr_waddr = A_MSTATUS;
                bus.csr_wdata = {bus.mstatus[31:13], 2'b11,
                                 bus.mstatus[10:8], bus.mstatus[3],
                                 bus.mstatus[6:4], 1'b0,
                                 bus.mstatus[2:0]};
                state_nx      = JUMP;
            end
            R_MSTAT: begin
                bus.csr_w     = 1'b1;
                bus.csr_waddr = A_MSTATUS;
                bus.csr_wdata = {bus.mstatus[31:8], 1'b1,
                                 bus.mstatus[6:4], bus.mstatus[7],
                                 bus.mstatus[2:0]};
                state_nx      = JUMP;
            end
            JUMP: begin
                bus.redirect = 1'b1;
                state_nx     = IDLE;
                if (ret_q) begin
                    bus.csr_raddr   = A_MEPC;
                    bus.redirect_pc = bus.csr_rdata;
                end else begin
                    bus.csr_raddr = A_MTVEC;
                    // Vectored mode offsets only interrupts, by 4 * cause code.
                    if (bus.csr_rdata[1:0] == 2'b01 && cause_q[31])
                        bus.redirect_pc = vec_base + 32'd44;
                    else
                        bus.redirect_pc = vec_base;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small CSR file model on the port.
// Expected CSR writes and redirect targets are hand-computed constants.
module tb_trap_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    trap_ctrl_if bus ();

    trap_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] r_mstatus = 32'd0;
    logic [31:0] r_mtvec   = 32'd0;
    logic [31:0] r_mepc    = 32'd0;
    logic [31:0] r_mcause  = 32'd0;
    logic [31:0] r_mtval   = 32'd0;
    logic        poke      = 1'b0;
    logic [11:0] poke_addr = 12'h0;
    logic [31:0] poke_data = 32'd0;

    // CSR file model: DUT writes, plus bench pokes while the DUT is idle.
    always @(posedge clk) begin
        if (bus.csr_w || poke) begin
            case (bus.csr_w ? bus.csr_waddr : poke_addr)
                12'h300: r_mstatus <= bus.csr_w ? bus.csr_wdata : poke_data;
                12'h305: r_mtvec   <= bus.csr_w ? bus.csr_wdata : poke_data;
                12'h341: r_mepc    <= bus.csr_w ? bus.csr_wdata : poke_data;
                12'h342: r_mcause  <= bus.csr_w ? bus.csr_wdata : poke_data;
                12'h343: r_mtval   <= bus.csr_w ? bus.csr_wdata : poke_data;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mstatus = r_mstatus;
        case (bus.csr_raddr)
            12'h305: bus.csr_rdata = r_mtvec;
            12'h341: bus.csr_rdata = r_mepc;
            12'h342: bus.csr_rdata = r_mcause;
            12'h343: bus.csr_rdata = r_mtval;
            default: bus.csr_rdata = r_mstatus;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        bus.wb_valid     = 1'b0;
        bus.trap_pc      = 32'd0;
        bus.trap_val     = 32'd0;
        bus.illegal_inst = 1'b0;
        bus.ecall        = 1'b0;
        bus.l_fault      = 1'b0;
        bus.s_fault      = 1'b0;
        bus.mret         = 1'b0;
        bus.irq_ext      = 1'b0;
    endtask

    task automatic set_csr(input logic [11:0] a, input logic [31:0] d);
        poke      = 1'b1;
        poke_addr = a;
        poke_data = d;
        step();
        poke = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [11:0] a,
                             input logic [31:0] d);
        #1;
        chk({tag, "_w"}, {31'd0, bus.csr_w}, 32'd1);
        chk({tag, "_addr"}, {20'd0, bus.csr_waddr}, {20'd0, a});
        chk({tag, "_data"}, bus.csr_wdata, d);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        chk({tag, "_redir"}, {31'd0, bus.redirect}, 32'd0);
    endtask

    // Called in cycle 1 after a trap was accepted; ends in cycle 6.
    task automatic run_trap(input string tag, input logic [31:0] pc,
                            input logic [31:0] cause, input logic [31:0] tval,
                            input logic [31:0] mst, input logic [31:0] rpc);
        expect_wr({tag, "_mepc"}, 12'h341, pc);
        step();
        expect_wr({tag, "_mcause"}, 12'h342, cause);
        step();
        expect_wr({tag, "_mtval"}, 12'h343, tval);
        step();
        expect_wr({tag, "_mstat"}, 12'h300, mst);
        step();
        clear_in();
        #1;
        chk({tag, "_jump_redir"}, {31'd0, bus.redirect}, 32'd1);
        chk({tag, "_jump_pc"}, bus.redirect_pc, rpc);
        chk({tag, "_jump_w"}, {31'd0, bus.csr_w}, 32'd0);
        chk({tag, "_jump_busy"}, {31'd0, bus.busy}, 32'd1);
        step();
        #1;
        chk({tag, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done_redir"}, {31'd0, bus.redirect}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got=%0d exp=0", checks);
        $fatal(1, "timeout");
    end

    initial begin
        clear_in();
        bus.wb_valid = 1'b1;
        bus.ecall    = 1'b1;
        #3;
        chk("rst_raddr", {20'd0, bus.csr_raddr}, 32'h300);
        chk("rst_mode", {30'd0, bus.csr_wsc_mode}, 32'd1);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_w", {31'd0, bus.csr_w}, 32'd0);
        chk("rst_redir", {31'd0, bus.redirect}, 32'd0);
        chk("rst_wdata", bus.csr_wdata, 32'd0);
        clear_in();
        step();
        rst = 1'b0;
        set_csr(12'h305, 32'h200);
        set_csr(12'h300, 32'h88);

        // Illegal instruction, direct mtvec.
        bus.wb_valid     = 1'b1;
        bus.illegal_inst = 1'b1;
        bus.trap_pc      = 32'h100;
        bus.trap_val     = 32'hFFFF_FFFF;
        #1;
        chk("ill_accept_busy", {31'd0, bus.busy}, 32'd1);
        chk("ill_accept_w", {31'd0, bus.csr_w}, 32'd0);
        step();
        clear_in();
        run_trap("ill", 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h1880, 32'h200);
        chk("ill_model_mstat", r_mstatus, 32'h1880);

        // Interrupt beats ecall, vectored mtvec.
        set_csr(12'h305, 32'h301);
        set_csr(12'h300, 32'h88);
        bus.wb_valid = 1'b1;
        bus.irq_ext  = 1'b1;
        bus.ecall    = 1'b1;
        bus.trap_pc  = 32'h40;
        bus.trap_val = 32'h1234;
        step();
        clear_in();
        run_trap("irq", 32'h40, 32'h8000_000B, 32'd0, 32'h1880, 32'h32C);

        // Masked interrupt, then mret re-enables it.
        set_csr(12'h300, 32'h80);
        set_csr(12'h341, 32'h104);
        bus.wb_valid = 1'b1;
        bus.irq_ext  = 1'b1;
        #1;
        chk("mask_busy", {31'd0, bus.busy}, 32'd0);
        chk("mask_w", {31'd0, bus.csr_w}, 32'd0);
        step();
        #1;
        chk("mask_busy2", {31'd0, bus.busy}, 32'd0);
        bus.mret = 1'b1;
        #1;
        chk("mret_accept", {31'd0, bus.busy}, 32'd1);
        step();
        bus.wb_valid = 1'b0;
        bus.mret     = 1'b0;
        expect_wr("mret_mstat", 12'h300, 32'h88);
        step();
        #1;
        chk("mret_redir", {31'd0, bus.redirect}, 32'd1);
        chk("mret_pc", bus.redirect_pc, 32'h104);
        chk("mret_raddr", {20'd0, bus.csr_raddr}, 32'h341);
        step();
        #1;
        chk("mret_done", {31'd0, bus.busy}, 32'd0);
        chk("irq_wait", {31'd0, bus.busy}, 32'd0);
        bus.wb_valid = 1'b1;
        bus.trap_pc  = 32'h108;
        #1;
        chk("irq_late_accept", {31'd0, bus.busy}, 32'd1);
        step();
        clear_in();
        run_trap("irqlate", 32'h108, 32'h8000_000B, 32'd0, 32'h1880,
                 32'h32C);

        // ecall together with mret: trap wins.
        set_csr(12'h305, 32'h200);
        set_csr(12'h300, 32'h1880);
        bus.wb_valid = 1'b1;
        bus.ecall    = 1'b1;
        bus.mret     = 1'b1;
        bus.trap_pc  = 32'h80;
        step();
        clear_in();
        run_trap("ecmret", 32'h80, 32'd11, 32'd0, 32'h1800, 32'h200);

        // Reset while in W_MCAUSE.
        set_csr(12'h342, 32'hAA);
        set_csr(12'h341, 32'h0);
        bus.wb_valid     = 1'b1;
        bus.illegal_inst = 1'b1;
        bus.trap_pc      = 32'h200;
        bus.trap_val     = 32'h5;
        step();
        clear_in();
        step();
        #1;
        chk("rstmid_pre", {20'd0, bus.csr_waddr}, 32'h342);
        rst = 1'b1;
        #1;
        chk("rstmid_w", {31'd0, bus.csr_w}, 32'd0);
        chk("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rstmid_redir", {31'd0, bus.redirect}, 32'd0);
            chk("rstmid_idle", {31'd0, bus.busy}, 32'd0);
            step();
        end
        chk("rstmid_mepc", r_mepc, 32'h200);
        chk("rstmid_mcause", r_mcause, 32'hAA);

        // Load fault, then store fault ignored while busy.
        set_csr(12'h300, 32'h1800);
        bus.wb_valid = 1'b1;
        bus.l_fault  = 1'b1;
        bus.trap_pc  = 32'h300;
        bus.trap_val = 32'hDEAD_0000;
        step();
        bus.l_fault  = 1'b0;
        bus.s_fault  = 1'b1;
        bus.trap_val = 32'h1234_5678;
        run_trap("lfault", 32'h300, 32'd5, 32'hDEAD_0000, 32'h1800, 32'h200);
        chk("lfault_mtval", r_mtval, 32'hDEAD_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
